// File: rtl/rv_data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_data_mem_responder_if
// Description : Load/store request and response channel between the core
//               (master) and the data memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/rv_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : rv_data_mem_responder
// Description : Word-organised data memory answering one RISC-V load/store at
//               a time after a fixed programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input wire clk,
    input wire reset,
    rv_data_mem_responder_if.slave bus
);
    localparam int         c_AW       = $clog2(DEPTH);
    localparam logic [3:0] c_CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam bit         c_NO_WAIT  = (LATENCY == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_we;
    logic [2:0]  w_funct3;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_half;
    logic        w_word;
    logic        w_legal;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_err;
    logic [31:0] w_old;
    logic [31:0] w_shifted;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_load;
    logic [31:0] w_new;
    logic [31:0] w_rdata;
    logic        w_enter_resp;
    logic        w_commit;

    assign w_accept = r_req_ready & bus.req_valid;

    // With zero latency the access executes on the acceptance edge itself,
    // so the decode must look at the live bus rather than the latched copy.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_we     = bus.req_we;
            w_funct3 = bus.req_funct3;
            w_addr   = bus.req_addr;
            w_wdata  = bus.req_wdata;
        end else begin
            w_we     = r_we;
            w_funct3 = r_funct3;
            w_addr   = r_addr;
            w_wdata  = r_wdata;
        end
    end

    always_comb begin
        w_half         = (w_funct3[1:0] == 2'b01);
        w_word         = (w_funct3[1:0] == 2'b10);
        w_legal        = w_we ? (w_funct3[2] == 1'b0 && w_funct3[1:0] != 2'b11)
                              : (w_funct3 != 3'b011 && w_funct3 != 3'b110 && w_funct3 != 3'b111);
        w_misaligned   = (w_half & w_addr[0]) | (w_word & (w_addr[1:0] != 2'b00));
        w_out_of_range = ({1'b0, w_addr[31:2]} >= 31'(DEPTH));
        w_err          = ~w_legal | w_misaligned | w_out_of_range;

        w_old     = r_mem[w_addr[c_AW+1:2]];
        w_shifted = w_old >> {w_addr[1:0], 3'b000};
        w_lane_b  = w_shifted[7:0];
        w_lane_h  = w_addr[1] ? w_old[31:16] : w_old[15:0];

        w_load = 32'd0;
        case (w_funct3)
            3'b000:  w_load = {{24{w_lane_b[7]}}, w_lane_b};
            3'b001:  w_load = {{16{w_lane_h[15]}}, w_lane_h};
            3'b010:  w_load = w_old;
            3'b100:  w_load = {24'd0, w_lane_b};
            3'b101:  w_load = {16'd0, w_lane_h};
            default: w_load = 32'd0;
        endcase

        w_new = w_old;
        case (w_funct3[1:0])
            2'b00:   w_new[{w_addr[1:0], 3'b000} +: 8]  = w_wdata[7:0];
            2'b01:   w_new[{w_addr[1], 4'b0000} +: 16]  = w_wdata[15:0];
            2'b10:   w_new = w_wdata;
            default: w_new = w_old;
        endcase

        w_rdata = (w_err | w_we) ? 32'd0 : w_load;
    end

    assign w_enter_resp = ((r_state == S_IDLE) & w_accept & c_NO_WAIT) |
                          ((r_state == S_WAIT) & (r_cnt == 4'd0));
    assign w_commit     = w_enter_resp & w_we & ~w_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we        <= bus.req_we;
                        r_funct3    <= bus.req_funct3;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        if (c_NO_WAIT) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rdata;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_CNT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rdata;
                        r_rsp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (r_rsp_valid & bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Memory contents survive reset; reset only suppresses an in-flight store.
    always_ff @(posedge clk) begin
        if (!reset && w_commit) begin
            r_mem[w_addr[c_AW+1:2]] <= w_new;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
endmodule
`default_nettype wire

// File: tb/tb_rv_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_data_mem_responder
// Description : Self-checking bench: directed vectors, corner sequences and
//               random accesses against a byte-addressed reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_data_mem_responder;
    localparam int c_DEPTH = 1024;
    localparam int c_LAT   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv_data_mem_responder_if bus2 ();
    rv_data_mem_responder_if bus0 ();

    // One driver set, steered to either the LATENCY=2 or LATENCY=0 instance.
    logic        sel;
    logic        m_req_valid;
    logic        m_req_we;
    logic [2:0]  m_f3;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_rsp_ready;

    assign bus2.req_valid  = m_req_valid & ~sel;
    assign bus2.req_we     = m_req_we;
    assign bus2.req_funct3 = m_f3;
    assign bus2.req_addr   = m_addr;
    assign bus2.req_wdata  = m_wdata;
    assign bus2.rsp_ready  = m_rsp_ready & ~sel;
    assign bus0.req_valid  = m_req_valid & sel;
    assign bus0.req_we     = m_req_we;
    assign bus0.req_funct3 = m_f3;
    assign bus0.req_addr   = m_addr;
    assign bus0.req_wdata  = m_wdata;
    assign bus0.rsp_ready  = m_rsp_ready & sel;

    logic        s_req_ready;
    logic        s_rsp_valid;
    logic        s_rsp_err;
    logic [31:0] s_rsp_rdata;
    assign s_req_ready = sel ? bus0.req_ready : bus2.req_ready;
    assign s_rsp_valid = sel ? bus0.rsp_valid : bus2.rsp_valid;
    assign s_rsp_err   = sel ? bus0.rsp_err   : bus2.rsp_err;
    assign s_rsp_rdata = sel ? bus0.rsp_rdata : bus2.rsp_rdata;

    rv_data_mem_responder #(.DEPTH(c_DEPTH), .LATENCY(c_LAT)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    rv_data_mem_responder #(.DEPTH(c_DEPTH), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] byte_mem [4*c_DEPTH];

    typedef struct {
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] exp_rdata;
        bit        exp_err;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=timeout required=handshake", name);
    endtask

    // Reference: little-endian byte memory, loads/stores assembled byte by byte.
    task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                         input bit [31:0] wdata, output logic [31:0] rd, output logic err);
        int     nbytes;
        longint val;
        case (f3)
            3'd0, 3'd4: nbytes = 1;
            3'd1, 3'd5: nbytes = 2;
            3'd2:       nbytes = 4;
            default:    nbytes = 0;
        endcase
        if (nbytes == 0 || (we && f3 > 3'd2))
            err = 1'b1;
        else
            err = ((longint'(addr) % nbytes) != 0) || ((longint'(addr) / 4) >= c_DEPTH);
        rd = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nbytes; i++) byte_mem[addr + i] = wdata[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < nbytes; i++) val += longint'(byte_mem[addr + i]) << (8*i);
                if (f3 < 3'd4 && nbytes < 4 && val >= (longint'(1) << (8*nbytes - 1)))
                    val -= (longint'(1) << (8*nbytes));
                rd = val[31:0];
            end
        end
    endtask

    // Waits for the response after an acceptance edge; lat counts rising edges
    // from acceptance up to the first edge at which rsp_valid is seen high.
    task automatic wait_rsp(output logic [31:0] rdata, output logic err, output int lat);
        logic busy_ready;
        busy_ready = 1'b0;
        lat = 0;
        m_rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            busy_ready |= s_req_ready;
            if (s_rsp_valid) break;
        end
        if (!s_rsp_valid) begin
            fail_timeout("rsp_valid_wait");
            rdata = 32'd0;
            err   = 1'b1;
            lat   = -1;
            return;
        end
        rdata = s_rsp_rdata;
        err   = s_rsp_err;
        chk("req_ready_while_busy", 32'(busy_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("post_handshake_idle", {28'd0, s_req_ready, s_rsp_valid, s_rsp_err, (s_rsp_rdata != 32'd0)},
            32'h8);
    endtask

    task automatic do_access(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                             input bit [31:0] wdata, output logic [31:0] rdata,
                             output logic err, output int lat);
        bit rdy;
        bit ok;
        m_req_we    = we;
        m_f3        = f3;
        m_addr      = addr;
        m_wdata     = wdata;
        m_req_valid = 1'b1;
        m_rsp_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            rdy = s_req_ready;
            @(posedge clk);
            ok = rdy;
        end
        #1;
        // Scramble the request after acceptance; the responder must ignore it.
        m_req_valid = 1'b0;
        m_req_we    = 1'($urandom);
        m_f3        = 3'($urandom);
        m_addr      = $urandom;
        m_wdata     = $urandom;
        if (!ok) begin
            fail_timeout("req_accept");
            rdata = 32'd0;
            err   = 1'b1;
            lat   = -1;
            return;
        end
        wait_rsp(rdata, err, lat);
    endtask

    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic        er;
    logic        exp_er;
    logic [31:0] held_rd;
    logic        stable;
    int          lat;
    bit          r_we;
    bit [2:0]    r_f3;
    bit [31:0]   r_addr;
    bit [31:0]   r_wdata;

    initial begin
        vt[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
        vt[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0};
        vt[3]  = '{1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1'b0};
        vt[4]  = '{1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0};
        vt[5]  = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD, 1'b0};
        vt[6]  = '{1'b1, 3'b000, 32'h11, 32'h00000055, 32'h0,        1'b0};
        vt[7]  = '{1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0,        1'b0};
        vt[8]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 1'b0};
        vt[9]  = '{1'b0, 3'b010, 32'h12, 32'h0,        32'h0,        1'b1};
        vt[10] = '{1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 32'h0,        1'b1};
        vt[11] = '{1'b0, 3'b010, 32'(4*c_DEPTH), 32'h0, 32'h0,       1'b1};
        vt[12] = '{1'b0, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1};
        vt[13] = '{1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1};
        vt[14] = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h123455EF, 1'b0};

        reset = 1'b1;
        sel = 1'b0;
        m_req_valid = 1'b0;
        m_req_we = 1'b0;
        m_f3 = 3'd0;
        m_addr = 32'd0;
        m_wdata = 32'd0;
        m_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state_lat2", {bus2.rsp_rdata[30:0], bus2.req_ready} | {31'd0, 1'b0}, 32'd1);
        chk("reset_flags_lat2", {30'd0, bus2.rsp_valid, bus2.rsp_err}, 32'd0);
        chk("reset_state_lat0", {bus0.rsp_rdata[30:0], bus0.req_ready}, 32'd1);
        reset = 1'b0;

        // Give words 0..15 known contents so random loads are well defined.
        for (int w = 0; w < 16; w++) begin
            model(1'b1, 3'b010, 32'(w*4), 32'h0, exp_rd, exp_er);
            do_access(1'b1, 3'b010, 32'(w*4), 32'h0, rd, er, lat);
            chk($sformatf("prewrite%0d_err", w), 32'(er), 32'd0);
        end

        for (int i = 0; i < 15; i++) begin
            model(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, exp_rd, exp_er);
            do_access(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(c_LAT + 1));
        end

        // Backpressure: response held for 5 cycles while a second request waits.
        m_req_we = 1'b0;
        m_f3 = 3'b010;
        m_addr = 32'h10;
        m_req_valid = 1'b1;
        m_rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        m_addr = 32'h14;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s_rsp_valid) break;
        end
        held_rd = s_rsp_rdata;
        chk("bp_rdata", held_rd, 32'h123455EF);
        stable = s_rsp_valid;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            stable &= s_rsp_valid & (s_rsp_rdata == held_rd) & ~s_rsp_err & ~s_req_ready;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        m_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", {30'd0, s_req_ready, s_rsp_valid}, 32'h2);
        @(posedge clk);
        #1;
        chk("bp_next_accept", 32'(s_req_ready), 32'd0);
        m_req_valid = 1'b0;
        model(1'b0, 3'b010, 32'h14, 32'h0, exp_rd, exp_er);
        wait_rsp(rd, er, lat);
        chk("bp_second_rdata", rd, exp_rd);
        chk("bp_second_latency", 32'(lat), 32'(c_LAT + 1));

        // Reset on the edge that would have committed a store in WAIT.
        m_req_we = 1'b1;
        m_f3 = 3'b010;
        m_addr = 32'h20;
        m_wdata = 32'h11111111;
        m_req_valid = 1'b1;
        @(posedge clk);
        #1;
        m_req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_wait_outputs", {28'd0, s_req_ready, s_rsp_valid, s_rsp_err, (s_rsp_rdata != 32'd0)},
            32'h8);
        model(1'b0, 3'b010, 32'h20, 32'h0, exp_rd, exp_er);
        do_access(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        chk("rst_wait_no_write", rd, exp_rd);

        for (int i = 0; i < 200; i++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_f3    = 3'($urandom_range(0, 7));
            r_wdata = $urandom;
            r_addr  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 19) == 0) r_addr = $urandom_range(32'h1000, 32'hFFFFFFFF);
            model(r_we, r_f3, r_addr, r_wdata, exp_rd, exp_er);
            do_access(r_we, r_f3, r_addr, r_wdata, rd, er, lat);
            chk($sformatf("rand%0d_rdata", i), rd, exp_rd);
            chk($sformatf("rand%0d_err", i), 32'(er), 32'(exp_er));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(c_LAT + 1));
        end

        // Zero-latency instance: response visible the cycle after acceptance.
        sel = 1'b1;
        #1;
        do_access(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, rd, er, lat);
        chk("lat0_sw_err", 32'(er), 32'd0);
        chk("lat0_sw_latency", 32'(lat), 32'd1);
        do_access(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
        chk("lat0_lw_rdata", rd, 32'hCAFEF00D);
        chk("lat0_lw_latency", 32'(lat), 32'd1);
        do_access(1'b0, 3'b000, 32'h42, 32'h0, rd, er, lat);
        chk("lat0_lb_rdata", rd, 32'hFFFFFFFE);
        do_access(1'b0, 3'b001, 32'h41, 32'h0, rd, er, lat);
        chk("lat0_lh_misaligned", {31'd0, er} | {rd[30:0], 1'b0}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule
`default_nettype wire
